// File: rtl/montgomery_bitserial_mul.sv
// rtl/montgomery_bitserial_mul.sv - radix-2 bit-serial Montgomery multiplier, result = a*b*2^-WIDTH mod m
module montgomery_bitserial_mul #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        REDUCE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] c_reg;
    logic [CW-1:0]    bit_idx;

    logic             last_bit;
    logic [WIDTH+1:0] sum_ab;
    logic [WIDTH+1:0] sum_m;
    logic [WIDTH+1:0] c_step;
    logic             c_ge_m;
    logic [WIDTH-1:0] reduced;

    // One Montgomery step; C < 2m keeps both partial sums inside WIDTH+2 bits.
    always_comb begin
        last_bit = (bit_idx == CW'(WIDTH - 1));
        sum_ab   = c_reg + (a_reg[bit_idx] ? {2'b00, b_reg} : '0);
        sum_m    = sum_ab + (sum_ab[0] ? {2'b00, m_reg} : '0);
        c_step   = sum_m >> 1;
        c_ge_m   = (c_reg >= {2'b00, m_reg});
        reduced  = c_ge_m ? (c_reg[WIDTH-1:0] - m_reg) : c_reg[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A sampled start always wins: it aborts whatever is in flight and restarts at bit 0.
    always_comb begin
        state_next = state;
        busy       = (state == COMPUTE) || (state == REDUCE);
        if (start) begin
            state_next = COMPUTE;
        end else begin
            case (state)
                COMPUTE: if (last_bit) state_next = REDUCE;
                REDUCE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            m_reg   <= '0;
            c_reg   <= '0;
            bit_idx <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_reg   <= in_a;
                b_reg   <= in_b;
                m_reg   <= in_m;
                c_reg   <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    COMPUTE: begin
                        c_reg   <= c_step;
                        bit_idx <= bit_idx + CW'(1);
                    end
                    REDUCE: begin
                        result <= reduced;
                        done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_montgomery_bitserial_mul.sv
// tb/tb_montgomery_bitserial_mul.sv - scoreboard bench for montgomery_bitserial_mul at WIDTH 8 and 512
module tb_montgomery_bitserial_mul;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start8;
    logic [7:0]  a8, b8, m8, res8;
    logic        done8, busy8;

    logic          startb;
    logic [511:0]  ab, bb, mb, resb;
    logic          doneb, busyb;

    montgomery_bitserial_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .in_a(a8), .in_b(b8), .in_m(m8),
        .result(res8), .done(done8), .busy(busy8)
    );

    montgomery_bitserial_mul #(.WIDTH(512)) dutb (
        .clk(clk), .reset(reset), .start(startb),
        .in_a(ab), .in_b(bb), .in_m(mb),
        .result(resb), .done(doneb), .busy(busyb)
    );

    int total = 0;
    int bad   = 0;
    logic [511:0] sb[$];

    logic         use_big;
    logic [511:0] res_s;
    logic         done_s, busy_s;

    always_comb begin
        res_s  = use_big ? resb : {504'd0, res8};
        done_s = use_big ? doneb : done8;
        busy_s = use_big ? busyb : busy8;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Brute-force x with x*2^8 == a*b (mod m).
    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        int p;
        p = (int'(a) * int'(b)) % int'(m);
        for (int x = 0; x < int'(m); x++) begin
            if (((x * 256) % int'(m)) == p) return 8'(x);
        end
        return 8'd0;
    endfunction

    // x * 2^k mod m by repeated modular doubling (x < m).
    function automatic logic [511:0] mul_pow2_mod(input logic [511:0] x, input logic [511:0] m, input int k);
        logic [512:0] r;
        r = {1'b0, x};
        for (int j = 0; j < k; j++) begin
            r = r << 1;
            if (r >= {1'b0, m}) r = r - {1'b0, m};
        end
        return r[511:0];
    endfunction

    task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        sb.push_back({504'd0, ref8(a, b, m)});
        a8 = a; b8 = b; m8 = m; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; m8 = 8'hff;
    endtask

    task automatic startb_op(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                             input logic [511:0] exp);
        sb.push_back(exp);
        ab = a; bb = b; mb = m; startb = 1'b1;
        @(posedge clk); #1;
        startb = 1'b0;
        ab = ~a; bb = ~b; mb = '1;
    endtask

    // Entered at #1 after the start edge; done must appear exactly lat edges later.
    task automatic wait_done(input int lat, input bit follow, input string tag);
        int n;
        int nbusy;
        logic [511:0] exp;
        logic [511:0] got;
        n = 0;
        nbusy = busy_s ? 1 : 0;
        while (n < lat + 4) begin
            @(posedge clk); #1;
            n++;
            if (done_s) break;
            if (busy_s) nbusy++;
        end
        check({tag, "_done_seen"}, {511'd0, done_s}, 512'd1);
        check({tag, "_latency"}, 512'(n), 512'(lat));
        check({tag, "_busy_cycles"}, 512'(nbusy), 512'(lat));
        got = res_s;
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 512'd0, 512'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, "_result"}, got, exp);
        end
        if (follow) begin
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, {511'd0, done_s}, 512'd0);
            check({tag, "_result_hold"}, res_s, got);
        end
    endtask

    initial begin
        logic [511:0] mbig, xbig, r2, xr;
        logic [7:0]   rm, ra, rb;

        use_big = 1'b0;
        start8 = 1'b0; startb = 1'b0;
        a8 = '0; b8 = '0; m8 = '0;
        ab = '0; bb = '0; mb = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", {504'd0, res8}, 512'd0);
        check("reset_done", {511'd0, done8}, 512'd0);
        check("reset_busy", {511'd0, busy8}, 512'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        start8_op(8'd5, 8'd7, 8'd13);
        check("s1_busy_after_start", {511'd0, busy8}, 512'd1);
        wait_done(9, 1'b1, "s1");

        start8_op(8'd12, 8'd12, 8'd13);
        wait_done(9, 1'b0, "s2a");
        start8_op(8'd9, 8'd1, 8'd13);
        check("s2_done_after_restart", {511'd0, done8}, 512'd0);
        check("s2_result_kept", {504'd0, res8}, 512'd3);
        wait_done(9, 1'b1, "s2b");
        start8_op(8'd0, 8'd7, 8'd13);
        wait_done(9, 1'b1, "s2c");

        for (int k = 0; k < 4; k++) begin
            rm = 8'($urandom_range(1, 127) * 2 + 1);
            ra = 8'($urandom_range(0, int'(rm) - 1));
            rb = 8'($urandom_range(0, int'(rm) - 1));
            start8_op(ra, rb, rm);
            wait_done(9, 1'b1, "rand8");
        end

        start8_op(8'd5, 8'd7, 8'd13);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            check("s4_no_early_done", {511'd0, done8}, 512'd0);
        end
        void'(sb.pop_back());
        start8_op(8'd12, 8'd12, 8'd13);
        wait_done(9, 1'b1, "s4");

        start8_op(8'd5, 8'd7, 8'd13);
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        check("s5_reset_done", {511'd0, done8}, 512'd0);
        check("s5_reset_busy", {511'd0, busy8}, 512'd0);
        check("s5_reset_result", {504'd0, res8}, 512'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        void'(sb.pop_back());
        @(posedge clk); #1;
        start8_op(8'd5, 8'd7, 8'd13);
        wait_done(9, 1'b1, "s5");

        use_big = 1'b1;
        for (int k = 0; k < 16; k++) begin
            mbig[k*32 +: 32] = $urandom;
            xbig[k*32 +: 32] = $urandom;
        end
        mbig[511] = 1'b1;
        mbig[0]   = 1'b1;
        xbig[511] = 1'b0;
        r2 = mul_pow2_mod(512'd1, mbig, 1024);
        xr = mul_pow2_mod(xbig, mbig, 512);
        startb_op(xbig, r2, mbig, xr);
        wait_done(513, 1'b1, "s3_to_mont");
        startb_op(resb, 512'd1, mbig, xbig);
        wait_done(513, 1'b1, "s3_from_mont");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
